// File: rtl/posted_write_memory.sv
`default_nettype none
// ============================================================================
// Module   : posted_write_memory
// Purpose  : Word-addressed memory with a posted-write FIFO buffer in front of
//            the array. Writes are queued and drained to the array on cycles
//            where the data-side port is not busy reading. Both read ports
//            forward the youngest matching buffered write.
// Ports    : Clock    - rising-edge clock
//            Reset    - asynchronous active-high reset
//            mem_addr - fetch-port address, looked up every cycle
//            addr     - data-port address for reads and writes
//            data     - write data
//            wr_en    - data-port write request
//            rd_en    - data-port read request
//            q        - registered data-port read result
//            q_mem    - registered fetch-port read result
//            stall    - buffer cannot accept a write this cycle
//            wb_empty - buffer holds no entries
// Revision : 1.0 - initial release
// ============================================================================
module posted_write_memory #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 5,
    parameter int WB_DEPTH   = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] q_mem,
    output logic                  stall,
    output logic                  wb_empty
);

    localparam int c_MEM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_PTR_W     = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int c_CNT_W     = $clog2(WB_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem     [c_MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wb_addr [WB_DEPTH];
    logic [DATA_WIDTH-1:0] r_wb_data [WB_DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] r_q_mem;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [c_PTR_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_fetch_word;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full   = (r_count == c_CNT_W'(WB_DEPTH));
    // A full buffer can still take a write when it drains on the same edge,
    // which only happens while the data port is not reading.
    assign stall    = w_full && rd_en;
    assign w_push   = wr_en && !stall;
    assign w_pop    = !rd_en && (r_count != '0);
    assign wb_empty = (r_count == '0);
    assign q        = r_q;
    assign q_mem    = r_q_mem;

    // Walk the live entries oldest to youngest so the youngest match wins.
    // Only entries present before the edge are searched, so a write accepted
    // on the same edge as a read is never forwarded to that read.
    always_comb begin
        w_idx        = '0;
        w_rd_word    = r_mem[addr];
        w_fetch_word = r_mem[mem_addr];
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (i < int'(r_count)) begin
                w_idx = c_PTR_W'((int'(r_head) + i) % WB_DEPTH);
                if (r_wb_addr[w_idx] == addr) begin
                    w_rd_word = r_wb_data[w_idx];
                end
                if (r_wb_addr[w_idx] == mem_addr) begin
                    w_fetch_word = r_wb_data[w_idx];
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < c_MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            for (int i = 0; i < WB_DEPTH; i++) begin
                r_wb_addr[i] <= '0;
                r_wb_data[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_q     <= '0;
            r_q_mem <= '0;
        end else begin
            if (w_pop) begin
                r_mem[r_wb_addr[r_head]] <= r_wb_data[r_head];
                r_head                   <= f_next(r_head);
            end
            if (w_push) begin
                r_wb_addr[r_tail] <= addr;
                r_wb_data[r_tail] <= data;
                r_tail            <= f_next(r_tail);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (rd_en) begin
                r_q <= w_rd_word;
            end
            r_q_mem <= w_fetch_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_posted_write_memory.sv
`default_nettype none
module tb_posted_write_memory;

    localparam int DW = 20;
    localparam int AW = 5;
    localparam int WB = 4;

    logic          Clock;
    logic          Reset;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] q;
    logic [DW-1:0] q_mem;
    logic          stall;
    logic          wb_empty;

    posted_write_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .WB_DEPTH  (WB)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .mem_addr(mem_addr),
        .addr    (addr),
        .data    (data),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .q       (q),
        .q_mem   (q_mem),
        .stall   (stall),
        .wb_empty(wb_empty)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ordered list of pending writes plus a plain array.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          m_q[$];
    logic [DW-1:0] m_mem[32];
    logic [DW-1:0] m_qv;
    logic          s_stall_pre;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] a;
        logic [AW-1:0] ma;
        logic [DW-1:0] d;
        logic [DW-1:0] eq;
        logic [DW-1:0] eqm;
        logic          es;
        logic          ee;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].a == a) return m_q[i].d;
        end
        return m_mem[a];
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_qv = '0;
    endtask

    // One clock cycle: drive, check stall before the edge, update the model
    // at the edge, check registered outputs just after it.
    task automatic step(input logic w, input logic r, input logic [AW-1:0] a,
                        input logic [AW-1:0] ma, input logic [DW-1:0] d);
        logic          es;
        logic [DW-1:0] eq;
        logic [DW-1:0] eqm;
        ent_t          e;
        wr_en    = w;
        rd_en    = r;
        addr     = a;
        mem_addr = ma;
        data     = d;
        #1;
        es = (m_q.size() == WB) && r;
        chk("stall", 32'(stall), 32'(es));
        s_stall_pre = stall;
        eq  = r ? lookup(a) : m_qv;
        eqm = lookup(ma);
        @(posedge Clock);
        if (!r && m_q.size() > 0) begin
            e = m_q.pop_front();
            m_mem[e.a] = e.d;
        end
        if (w && !es) begin
            e.a = a;
            e.d = d;
            m_q.push_back(e);
        end
        m_qv = eq;
        #1;
        chk("q", 32'(q), 32'(eq));
        chk("q_mem", 32'(q_mem), 32'(eqm));
        chk("wb_empty", 32'(wb_empty), 32'(m_q.size() == 0));
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [AW-1:0] a,
                                input logic [AW-1:0] ma, input logic [DW-1:0] d,
                                input logic [DW-1:0] eq, input logic [DW-1:0] eqm,
                                input logic es, input logic ee);
        vec_t v;
        v.wr = wr; v.rd = rd; v.a = a; v.ma = ma; v.d = d;
        v.eq = eq; v.eqm = eqm; v.es = es; v.ee = ee;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 0, 3, 20'h0,     20'h0,     20'h0,     0, 1);
        vecs[1]  = mk(1, 1, 5, 5, 20'h0ABCD, 20'h0,     20'h0,     0, 0);
        vecs[2]  = mk(0, 1, 5, 5, 20'h0,     20'h0ABCD, 20'h0ABCD, 0, 0);
        vecs[3]  = mk(0, 0, 0, 5, 20'h0,     20'h0ABCD, 20'h0ABCD, 0, 1);
        vecs[4]  = mk(1, 1, 1, 5, 20'h11111, 20'h0,     20'h0ABCD, 0, 0);
        vecs[5]  = mk(1, 1, 2, 5, 20'h22222, 20'h0,     20'h0ABCD, 0, 0);
        vecs[6]  = mk(1, 1, 3, 5, 20'h33333, 20'h0,     20'h0ABCD, 0, 0);
        vecs[7]  = mk(1, 1, 4, 5, 20'h44444, 20'h0,     20'h0ABCD, 0, 0);
        vecs[8]  = mk(1, 1, 9, 5, 20'h99999, 20'h0,     20'h0ABCD, 1, 0);
        vecs[9]  = mk(0, 0, 0, 5, 20'h0,     20'h0,     20'h0ABCD, 0, 0);
        vecs[10] = mk(0, 0, 0, 5, 20'h0,     20'h0,     20'h0ABCD, 0, 0);
        vecs[11] = mk(0, 0, 0, 5, 20'h0,     20'h0,     20'h0ABCD, 0, 0);
        vecs[12] = mk(0, 0, 0, 5, 20'h0,     20'h0,     20'h0ABCD, 0, 1);
        vecs[13] = mk(0, 1, 1, 5, 20'h0,     20'h11111, 20'h0ABCD, 0, 1);
        vecs[14] = mk(0, 1, 4, 5, 20'h0,     20'h44444, 20'h0ABCD, 0, 1);
        vecs[15] = mk(0, 1, 9, 5, 20'h0,     20'h0,     20'h0ABCD, 0, 1);

        Reset = 1'b1; wr_en = 0; rd_en = 0; addr = '0; mem_addr = '0; data = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_q_mem", 32'(q_mem), 32'h0);
        chk("reset_wb_empty", 32'(wb_empty), 32'h1);
        @(negedge Clock);
        Reset = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].ma, vecs[i].d);
            chk($sformatf("vec%0d_stall", i), 32'(s_stall_pre), 32'(vecs[i].es));
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].eq));
            chk($sformatf("vec%0d_q_mem", i), 32'(q_mem), 32'(vecs[i].eqm));
            chk($sformatf("vec%0d_wb_empty", i), 32'(wb_empty), 32'(vecs[i].ee));
        end

        // Same-address writes drain in order
        step(1, 1, 7, 7, 20'h00011);
        step(1, 1, 7, 7, 20'h00022);
        step(0, 0, 0, 7, 20'h0);
        step(0, 0, 0, 7, 20'h0);
        chk("same_addr_empty", 32'(wb_empty), 32'h1);
        step(0, 0, 0, 7, 20'h0);
        chk("same_addr_q_mem", 32'(q_mem), 32'h00022);

        // Full buffer accepts a write when it drains on the same edge
        for (int i = 0; i < 4; i++) step(1, 1, 5'(20 + i), 7, 20'(32'h100 + i));
        step(1, 0, 24, 24, 20'h0BEEF);
        chk("full_drain_stall", 32'(s_stall_pre), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 24, 20'h0);
        chk("full_drain_count4", 32'(wb_empty), 32'h0);
        step(0, 0, 0, 24, 20'h0);
        chk("full_drain_empty", 32'(wb_empty), 32'h1);
        chk("full_drain_data", 32'(q_mem), 32'h0BEEF);

        // Reset with pending entries
        step(1, 1, 10, 7, 20'h0AAAA);
        step(1, 1, 11, 7, 20'h0BBBB);
        step(1, 1, 7, 7, 20'h0CCCC);
        chk("pre_reset_q", 32'(q), 32'h00022);
        #2 Reset = 1'b1;
        #1;
        chk("async_reset_wb_empty", 32'(wb_empty), 32'h1);
        chk("async_reset_q", 32'(q), 32'h0);
        chk("async_reset_q_mem", 32'(q_mem), 32'h0);
        model_reset();
        @(negedge Clock);
        Reset = 1'b0;
        step(0, 1, 10, 11, 20'h0);
        chk("post_reset_q", 32'(q), 32'h0);
        chk("post_reset_q_mem", 32'(q_mem), 32'h0);
        step(0, 1, 7, 7, 20'h0);
        chk("post_reset_q7", 32'(q), 32'h0);

        // Randomized traffic on a narrow address range to force collisions
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 6),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 20'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
